// File: rtl/lock_reset_sequencer.sv
// Lock-qualified reset sequencer: synchronises PLL lock, waits for a stable
// settle window, then releases active-low domain resets one after another.
module lock_reset_sequencer #(
  parameter int NUM_OUT        = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               locked_in,
  input  logic               soft_rst,
  output logic [NUM_OUT-1:0] rstn_out,
  output logic               ready,
  output logic               lost_lock,
  output logic [CNT_W-1:0]   loss_count,
  output logic [2:0]         state_o
);

  localparam int REL_SPAN = (NUM_OUT - 1) * STAGGER_CYCLES + 1;
  localparam int CNT_MAX  = (SETTLE_CYCLES > REL_SPAN) ? SETTLE_CYCLES : REL_SPAN;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_OUT-1:0]     rstn_q, rstn_d;
  logic                   ready_q, ready_d;
  logic                   lost_q, lost_d;
  logic [CNT_W-1:0]       loss_q, loss_d;

  logic                   lock_s;
  logic [NUM_OUT-1:0]     rel_hit;

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Bit gi of the reset vector is due when the release counter reaches gi*STAGGER.
  generate
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_rel_hit
      localparam logic [CW-1:0] HIT_AT = CW'(gi * STAGGER_CYCLES);
      assign rel_hit[gi] = (cnt_q == HIT_AT);
    end
  endgenerate

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], locked_in};
    state_d = state_q;
    cnt_d   = cnt_q;
    rstn_d  = rstn_q;
    ready_d = ready_q;
    lost_d  = 1'b0;
    loss_d  = loss_q;

    case (state_q)
      WAIT_LOCK: begin
        rstn_d  = '0;
        ready_d = 1'b0;
        cnt_d   = '0;
        if (lock_s) begin
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        if (!lock_s) begin
          // Drop before any release is only a failed settle, not a loss event.
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (soft_rst) begin
          state_d = SETTLE;
          cnt_d   = '0;
          rstn_d  = '0;
          ready_d = 1'b0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RELEASE, RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          rstn_d  = '0;
          ready_d = 1'b0;
          lost_d  = 1'b1;
          if (loss_q != {CNT_W{1'b1}}) begin
            loss_d = loss_q + CNT_W'(1);
          end
        end else if (soft_rst) begin
          state_d = SETTLE;
          cnt_d   = '0;
          rstn_d  = '0;
          ready_d = 1'b0;
        end else if (state_q == RELEASE) begin
          rstn_d = rstn_q | rel_hit;
          if (rel_hit[NUM_OUT-1]) begin
            state_d = RUN;
            ready_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
        rstn_d  = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      sync_q  <= '0;
      cnt_q   <= '0;
      rstn_q  <= '0;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      rstn_q  <= rstn_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
      loss_q  <= loss_d;
    end
  end

  assign rstn_out   = rstn_q;
  assign ready      = ready_q;
  assign lost_lock  = lost_q;
  assign loss_count = loss_q;
  assign state_o    = {1'b0, state_q};

endmodule

// File: tb/tb_lock_reset_sequencer.sv
// Bench for lock_reset_sequencer: directed scenarios plus random lock/soft-reset
// traffic, checked every cycle against an elapsed-time model of the sequence.
module tb_lock_reset_sequencer;

  localparam int NUM_OUT     = 3;
  localparam int SYNC_STAGES = 2;
  localparam int SETTLE      = 8;
  localparam int STAGGER     = 4;
  localparam int CNT_W       = 2;
  localparam int RUN_AT      = SETTLE + (NUM_OUT - 1) * STAGGER + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               locked_in;
  logic               soft_rst;
  logic [NUM_OUT-1:0] rstn_out;
  logic               ready;
  logic               lost_lock;
  logic [CNT_W-1:0]   loss_count;
  logic [2:0]         state_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: lock delay line, whether a sequence is active, and cycles elapsed
  // since it (re)started in SETTLE; every output is a closed-form function of those.
  bit m_sync[SYNC_STAGES];
  bit m_active;
  int m_el;
  int m_loss;
  bit m_pulse;

  lock_reset_sequencer #(
    .NUM_OUT        (NUM_OUT),
    .SYNC_STAGES    (SYNC_STAGES),
    .SETTLE_CYCLES  (SETTLE),
    .STAGGER_CYCLES (STAGGER),
    .CNT_W          (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .locked_in  (locked_in),
    .soft_rst   (soft_rst),
    .rstn_out   (rstn_out),
    .ready      (ready),
    .lost_lock  (lost_lock),
    .loss_count (loss_count),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  function automatic int exp_state();
    if (!m_active) return 0;
    if (m_el < SETTLE) return 1;
    if (m_el < RUN_AT) return 2;
    return 3;
  endfunction

  function automatic logic [NUM_OUT-1:0] exp_rstn();
    logic [NUM_OUT-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (m_active && m_el >= SETTLE + 1 + i * STAGGER) r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit ls;
    ls = m_sync[SYNC_STAGES-1];
    m_pulse = 1'b0;
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = 1'b0;
      m_active = 1'b0;
      m_el     = 0;
      m_loss   = 0;
      return;
    end
    if (!m_active) begin
      if (ls) begin
        m_active = 1'b1;
        m_el     = 0;
      end
    end else if (!ls) begin
      if (m_el >= SETTLE) begin
        m_pulse = 1'b1;
        if (m_loss < (1 << CNT_W) - 1) m_loss++;
      end
      m_active = 1'b0;
    end else if (soft_rst) begin
      m_el = 0;
    end else if (m_el < 100000) begin
      m_el++;
    end
    for (int i = SYNC_STAGES - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = locked_in;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("rstn_out",   32'(rstn_out),   32'(exp_rstn()));
    chk("ready",      32'(ready),      32'(exp_state() == 3));
    chk("lost_lock",  32'(lost_lock),  32'(m_pulse));
    chk("loss_count", 32'(loss_count), 32'(m_loss));
    chk("state",      32'(state_o),    32'(exp_state()));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    rst       = 1'b1;
    locked_in = 1'b0;
    soft_rst  = 1'b0;
    repeat (3) step();
    chk("reset_rstn", 32'(rstn_out), 32'd0);
    chk("reset_state", 32'(state_o), 32'd0);
    rst = 1'b0;
    repeat (4) step();

    // Clean lock: two synchroniser edges bring us to cycle t.
    locked_in = 1'b1;
    step();
    step();
    for (int k = 1; k <= 18; k++) begin
      step();
      if (k == 1)  chk("s1_state_t1", 32'(state_o), 32'd1);
      if (k == 8)  chk("s1_state_t8", 32'(state_o), 32'd1);
      if (k == 9)  chk("s1_state_t9", 32'(state_o), 32'd2);
      if (k == 10) chk("s1_rstn_t10", 32'(rstn_out), 32'b001);
      if (k == 14) chk("s1_rstn_t14", 32'(rstn_out), 32'b011);
      if (k == 17) chk("s1_ready_t17", 32'(ready), 32'd0);
      if (k == 18) begin
        chk("s1_rstn_t18", 32'(rstn_out), 32'b111);
        chk("s1_ready_t18", 32'(ready), 32'd1);
        chk("s1_loss", 32'(loss_count), 32'd0);
      end
    end
    $display("scenario 1 clean lock: rstn_out=%b ready=%0d cycle=%0d", rstn_out, ready, cyc);

    // Glitch during settle: lock_s low only at t+5.
    do_reset();
    locked_in = 1'b1;
    step();
    step();
    repeat (3) step();
    locked_in = 1'b0;
    step();
    locked_in = 1'b1;
    step();
    step();
    chk("s2_state_t6", 32'(state_o), 32'd0);
    chk("s2_rstn_t6", 32'(rstn_out), 32'd0);
    chk("s2_loss_t6", 32'(loss_count), 32'd0);
    repeat (25) step();
    chk("s2_relock_rstn", 32'(rstn_out), 32'b111);
    $display("scenario 2 settle glitch: loss_count=%0d state=%0d cycle=%0d", loss_count, state_o, cyc);

    // Loss mid-release, then again in RUN.
    do_reset();
    locked_in = 1'b1;
    step();
    step();
    repeat (13) step();
    locked_in = 1'b0;
    step();
    locked_in = 1'b1;
    step();
    chk("s3_rstn_t15", 32'(rstn_out), 32'b011);
    step();
    chk("s3_rstn_t16", 32'(rstn_out), 32'd0);
    chk("s3_pulse_t16", 32'(lost_lock), 32'd1);
    chk("s3_loss_t16", 32'(loss_count), 32'd1);
    step();
    chk("s3_pulse_t17", 32'(lost_lock), 32'd0);
    repeat (25) step();
    locked_in = 1'b0;
    repeat (3) step();
    chk("s3_loss_run", 32'(loss_count), 32'd2);
    locked_in = 1'b1;
    repeat (25) step();
    $display("scenario 3 loss release/run: loss_count=%0d cycle=%0d", loss_count, cyc);

    // Saturation over five losses from RUN.
    do_reset();
    locked_in = 1'b1;
    for (int n = 0; n < 5; n++) begin
      repeat (22) step();
      chk("s4_in_run", 32'(state_o), 32'd3);
      locked_in = 1'b0;
      repeat (3) step();
      chk("s4_pulse", 32'(lost_lock), 32'd1);
      chk("s4_loss", 32'(loss_count), 32'(sat_exp[n]));
      locked_in = 1'b1;
      $display("scenario 4 loss %0d: loss_count=%0d cycle=%0d", n + 1, loss_count, cyc);
    end

    // soft_rst held three cycles in RUN.
    repeat (22) step();
    chk("s5_in_run", 32'(state_o), 32'd3);
    soft_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("s5_rstn_held", 32'(rstn_out), 32'd0);
      chk("s5_state_held", 32'(state_o), 32'd1);
    end
    soft_rst = 1'b0;
    repeat (16) step();
    chk("s5_rstn_early", 32'(rstn_out), 32'b011);
    step();
    chk("s5_rstn_done", 32'(rstn_out), 32'b111);
    chk("s5_loss", 32'(loss_count), 32'd3);
    $display("scenario 5 soft_rst: rstn_out=%b loss_count=%0d cycle=%0d", rstn_out, loss_count, cyc);

    // Lock loss coinciding with soft_rst, then rst during RELEASE.
    do_reset();
    locked_in = 1'b1;
    repeat (22) step();
    locked_in = 1'b0;
    step();
    step();
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    chk("s6_state", 32'(state_o), 32'd0);
    chk("s6_pulse", 32'(lost_lock), 32'd1);
    chk("s6_loss", 32'(loss_count), 32'd1);
    locked_in = 1'b1;
    for (int k = 0; k < 40 && exp_state() != 2; k++) step();
    chk("s6_reached_release", 32'(exp_state()), 32'd2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s6_rst_rstn", 32'(rstn_out), 32'd0);
    chk("s6_rst_ready", 32'(ready), 32'd0);
    chk("s6_rst_loss", 32'(loss_count), 32'd0);
    chk("s6_rst_state", 32'(state_o), 32'd0);
    $display("scenario 6 simultaneous/reset: state=%0d loss_count=%0d cycle=%0d", state_o, loss_count, cyc);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(49) == 0) locked_in = ~locked_in;
      soft_rst = ($urandom_range(59) == 0) ? 1'b1 : (soft_rst && ($urandom_range(2) != 0));
      rst      = ($urandom_range(599) == 0);
      step();
    end
    rst = 1'b0;
    $display("random phase done: loss_count=%0d cycle=%0d", loss_count, cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
